dlx_lsu_mem_ctrl: RTL and testbench



---
 rtl/dlx_lsu_mem_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_dlx_lsu_mem_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dlx_lsu_mem_ctrl.sv
// DLX load/store controller: turns byte/half/word CPU accesses into word-only memory
// transactions (big-endian lanes, read-modify-write for sub-word stores).
module dlx_lsu_mem_ctrl #(
    parameter int unsigned ADDRESS_SIZE   = 16,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_req,
    input  logic                    mem_we,
    input  logic [1:0]              mem_size,
    input  logic                    mem_signed,
    input  logic [ADDRESS_SIZE-1:0] mem_addr,
    input  logic [31:0]             mem_wdata,
    output logic                    stall,
    output logic [31:0]             load_data,
    output logic                    done,
    output logic                    err,
    output logic [1:0]              err_code,
    output logic                    ENABLE,
    output logic                    READNOTWRITE,
    output logic [ADDRESS_SIZE-1:0] ADDRESS,
    output logic [31:0]             DATA_OUT,
    output logic                    DATA_OE,
    input  logic [31:0]             DATA_IN,
    input  logic                    DATA_READY
);

    localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StRd    = 3'd1;
    localparam logic [2:0] StRmwRd = 3'd2;
    localparam logic [2:0] StGap   = 3'd3;
    localparam logic [2:0] StWr    = 3'd4;
    localparam logic [2:0] StDone  = 3'd5;

    logic [2:0]              state_q, state_d;
    logic [CntWidth-1:0]     cnt_q, cnt_d, cnt_inc;
    logic                    we_q;
    logic [1:0]              size_q;
    logic                    signed_q;
    logic [ADDRESS_SIZE-1:0] addr_q;
    logic [31:0]             wdata_q;
    logic [31:0]             load_q, load_d;
    logic [31:0]             wbuf_q, wbuf_d;
    logic                    err_q, err_d;
    logic [1:0]              code_q, code_d;
    logic                    enable_q, rnw_q, oe_q;
    logic                    latch;
    logic                    misaligned;
    logic                    access_d;

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] off, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = off[1] ? w[15:0] : w[31:16];
        case (sz)
            2'b00:   return {{24{sgn & b[7]}}, b};
            2'b01:   return {{16{sgn & h[15]}}, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                          input logic [1:0] sz, input logic [1:0] off);
        logic [31:0] r;
        r = w;
        if (sz == 2'b00) begin
            case (off)
                2'd0:    r[31:24] = d[7:0];
                2'd1:    r[23:16] = d[7:0];
                2'd2:    r[15:8]  = d[7:0];
                default: r[7:0]   = d[7:0];
            endcase
        end else if (off[1]) begin
            r[15:0] = d[15:0];
        end else begin
            r[31:16] = d[15:0];
        end
        return r;
    endfunction

    assign misaligned = (mem_size == 2'b11) ||
                        (mem_size == 2'b01 && mem_addr[0]) ||
                        (mem_size == 2'b10 && mem_addr[1:0] != 2'b00);
    assign cnt_inc    = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_d  = load_q;
        wbuf_d  = wbuf_q;
        err_d   = err_q;
        code_d  = code_q;
        latch   = 1'b0;
        case (state_q)
            StIdle: begin
                if (mem_req) begin
                    latch = 1'b1;
                    cnt_d = '0;
                    if (misaligned) begin
                        state_d = StDone;
                        err_d   = 1'b1;
                        code_d  = 2'b01;
                    end else begin
                        err_d  = 1'b0;
                        code_d = 2'b00;
                        if (!mem_we) begin
                            state_d = StRd;
                        end else if (mem_size == 2'b10) begin
                            state_d = StWr;
                            wbuf_d  = mem_wdata;
                        end else begin
                            state_d = StRmwRd;
                        end
                    end
                end
            end
            StRd, StRmwRd, StWr: begin
                if (DATA_READY) begin
                    if (state_q == StRd) begin
                        load_d  = extract(DATA_IN, size_q, addr_q[1:0], signed_q);
                        state_d = StDone;
                    end else if (state_q == StRmwRd) begin
                        wbuf_d  = merge(DATA_IN, wdata_q, size_q, addr_q[1:0]);
                        state_d = StGap;
                    end else begin
                        state_d = StDone;
                    end
                end else if (cnt_inc == CntWidth'(TIMEOUT_CYCLES)) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                    code_d  = 2'b10;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StGap: begin
                // one idle cycle lets the memory drop DATA_READY before the write
                state_d = StWr;
                cnt_d   = '0;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign access_d = (state_d == StRd) || (state_d == StRmwRd) || (state_d == StWr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            load_q   <= '0;
            wbuf_q   <= '0;
            err_q    <= 1'b0;
            code_q   <= 2'b00;
            enable_q <= 1'b0;
            rnw_q    <= 1'b1;
            oe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            load_q   <= load_d;
            wbuf_q   <= wbuf_d;
            err_q    <= err_d;
            code_q   <= code_d;
            enable_q <= access_d;
            rnw_q    <= (state_d != StWr);
            oe_q     <= (state_d == StWr);
            if (latch) begin
                we_q     <= mem_we;
                size_q   <= mem_size;
                signed_q <= mem_signed;
                addr_q   <= mem_addr;
                wdata_q  <= mem_wdata;
            end
        end
    end

    assign stall        = (state_q == StIdle && mem_req) ||
                          (state_q != StIdle && state_q != StDone);
    assign done         = (state_q == StDone);
    assign err          = done & err_q;
    assign err_code     = done ? code_q : 2'b00;
    assign load_data    = load_q;
    assign ENABLE       = enable_q;
    assign READNOTWRITE = rnw_q;
    assign DATA_OE      = oe_q;
    assign DATA_OUT     = wbuf_q;
    assign ADDRESS      = {addr_q[ADDRESS_SIZE-1:2], 2'b00};

    logic unused_we;
    assign unused_we = we_q;

endmodule

// File: tb/tb_dlx_lsu_mem_ctrl.sv
// Bench for dlx_lsu_mem_ctrl: vector table through a scoreboard queue, a 1-cycle memory
// model, plus a reset-during-write sequence.
module tb_dlx_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req = 1'b0, mem_we = 1'b0, mem_signed = 1'b0;
    logic [1:0]  mem_size = 2'b00;
    logic [15:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        stall, done, err, enable, rnw, data_oe;
    logic [1:0]  err_code;
    logic [31:0] load_data, data_out;
    logic [15:0] address;
    logic [31:0] data_in = '0;
    logic        data_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:16383];
    logic        hang = 1'b0;
    logic        pre_req = 1'b0;
    logic [13:0] pre_addr = '0;
    logic [31:0] pre_val = '0;

    always #5 clk = ~clk;

    dlx_lsu_mem_ctrl #(.ADDRESS_SIZE(16), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
        .mem_signed(mem_signed), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .stall(stall),
        .load_data(load_data), .done(done), .err(err), .err_code(err_code), .ENABLE(enable),
        .READNOTWRITE(rnw), .ADDRESS(address), .DATA_OUT(data_out), .DATA_OE(data_oe),
        .DATA_IN(data_in), .DATA_READY(data_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory: answers one cycle after ENABLE, drops DATA_READY for a cycle after each access.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            data_ready <= 1'b0;
        end else begin
            if (pre_req) mem[pre_addr] <= pre_val;
            if (enable && !data_ready && !hang) begin
                data_ready <= 1'b1;
                chk("addr_word_aligned", {30'd0, address[1:0]}, 32'd0);
                if (rnw) begin
                    data_in <= mem[address[15:2]];
                end else begin
                    chk("data_oe_on_write", {31'd0, data_oe}, 32'd1);
                    mem[address[15:2]] <= data_out;
                end
            end else begin
                data_ready <= 1'b0;
            end
        end
    end

    typedef struct {
        logic        hang;
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] pre;
        logic [31:0] exp_data;
        logic        exp_err;
        logic [1:0]  exp_code;
        int          exp_cyc;
        logic [15:0] exp_mask;
    } vec_t;

    vec_t        sb_q[$];
    logic [31:0] last_load = '0;

    function automatic vec_t mk(input logic hg, input logic we, input logic [1:0] sz,
                                input logic sg, input logic [15:0] a, input logic [31:0] wd,
                                input logic [31:0] pr, input logic [31:0] ed, input logic ee,
                                input logic [1:0] ec, input int cy, input logic [15:0] m);
        vec_t v;
        v.hang = hg; v.we = we; v.size = sz; v.sgn = sg; v.addr = a; v.wdata = wd;
        v.pre = pr; v.exp_data = ed; v.exp_err = ee; v.exp_code = ec; v.exp_cyc = cy;
        v.exp_mask = m;
        return v;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        vec_t        e;
        int          n;
        int          cyc;
        logic        got;
        logic        stall_bad;
        logic [15:0] mask;
        logic [31:0] ld;
        logic        er;
        logic [1:0]  ec;
        string       t;
        t = $sformatf("v%0d", idx);
        @(posedge clk);
        #1;
        pre_addr = v.addr[15:2];
        pre_val  = v.pre;
        pre_req  = 1'b1;
        hang     = v.hang;
        @(posedge clk);
        #1;
        pre_req    = 1'b0;
        mem_req    = 1'b1;
        mem_we     = v.we;
        mem_size   = v.size;
        mem_signed = v.sgn;
        mem_addr   = v.addr;
        mem_wdata  = v.wdata;
        sb_q.push_back(v);
        n = 0; cyc = -1; got = 1'b0; stall_bad = 1'b0; mask = '0;
        ld = '0; er = 1'b0; ec = 2'b00;
        while (!got && n < 40) begin
            @(negedge clk);
            if (enable && n < 16) mask[n] = 1'b1;
            if (done) begin
                got = 1'b1;
                cyc = n;
                ld  = load_data;
                er  = err;
                ec  = err_code;
                if (stall) stall_bad = 1'b1;
            end else if (!stall) begin
                stall_bad = 1'b1;
            end
            n++;
        end
        @(posedge clk);
        #1;
        mem_req = 1'b0;
        hang    = 1'b0;
        e = sb_q.pop_front();
        chk({t, "_done_seen"}, {31'd0, got}, 32'd1);
        if (!got) return;
        chk({t, "_done_cycle"}, cyc, e.exp_cyc);
        chk({t, "_err"}, {31'd0, er}, {31'd0, e.exp_err});
        chk({t, "_err_code"}, {30'd0, ec}, {30'd0, e.exp_code});
        chk({t, "_enable_cycles"}, {16'd0, mask}, {16'd0, e.exp_mask});
        chk({t, "_stall"}, {31'd0, stall_bad}, 32'd0);
        if (e.exp_err) begin
            chk({t, "_load_held"}, ld, last_load);
        end else if (e.we) begin
            chk({t, "_mem_word"}, mem[e.addr[15:2]], e.exp_data);
        end else begin
            chk({t, "_load_data"}, ld, e.exp_data);
            last_load = e.exp_data;
        end
    endtask

    vec_t vecs[19];
    logic saw_done;

    initial begin
        //           hang we  size  sgn addr      wdata         pre           expected
        vecs[0]  = mk(0, 0, 2'b10, 0, 16'h0010, 32'h0,        32'h800000F0, 32'h800000F0, 0, 2'b00, 3, 16'h0006);
        vecs[1]  = mk(0, 0, 2'b00, 1, 16'h0010, 32'h0,        32'h800000F0, 32'hFFFFFF80, 0, 2'b00, 3, 16'h0006);
        vecs[2]  = mk(0, 0, 2'b00, 0, 16'h0013, 32'h0,        32'h800000F0, 32'h000000F0, 0, 2'b00, 3, 16'h0006);
        vecs[3]  = mk(0, 0, 2'b01, 1, 16'h0012, 32'h0,        32'h800000F0, 32'h000000F0, 0, 2'b00, 3, 16'h0006);
        vecs[4]  = mk(0, 0, 2'b01, 1, 16'h0010, 32'h0,        32'h800000F0, 32'hFFFF8000, 0, 2'b00, 3, 16'h0006);
        vecs[5]  = mk(0, 0, 2'b01, 0, 16'h0010, 32'h0,        32'h800000F0, 32'h00008000, 0, 2'b00, 3, 16'h0006);
        vecs[6]  = mk(0, 0, 2'b00, 0, 16'h0011, 32'h0,        32'h800000F0, 32'h00000000, 0, 2'b00, 3, 16'h0006);
        vecs[7]  = mk(0, 0, 2'b00, 1, 16'h0013, 32'h0,        32'h800000F0, 32'hFFFFFFF0, 0, 2'b00, 3, 16'h0006);
        vecs[8]  = mk(0, 1, 2'b00, 0, 16'h0011, 32'h000000AB, 32'h11223344, 32'h11AB3344, 0, 2'b00, 6, 16'h0036);
        vecs[9]  = mk(0, 1, 2'b01, 0, 16'h0016, 32'h0000BEEF, 32'h11223344, 32'h1122BEEF, 0, 2'b00, 6, 16'h0036);
        vecs[10] = mk(0, 1, 2'b00, 0, 16'h0023, 32'hFFFFFF5A, 32'hAABBCCDD, 32'hAABBCC5A, 0, 2'b00, 6, 16'h0036);
        vecs[11] = mk(0, 1, 2'b10, 0, 16'h0018, 32'hCAFEF00D, 32'h00000000, 32'hCAFEF00D, 0, 2'b00, 3, 16'h0006);
        vecs[12] = mk(0, 1, 2'b01, 1, 16'h0020, 32'h00001234, 32'hAABBCCDD, 32'h1234CCDD, 0, 2'b00, 6, 16'h0036);
        vecs[13] = mk(0, 0, 2'b10, 0, 16'h0012, 32'h0,        32'h800000F0, 32'h0,        1, 2'b01, 1, 16'h0000);
        vecs[14] = mk(0, 1, 2'b01, 0, 16'h0011, 32'h0000FFFF, 32'h800000F0, 32'h0,        1, 2'b01, 1, 16'h0000);
        vecs[15] = mk(0, 0, 2'b11, 0, 16'h0010, 32'h0,        32'h800000F0, 32'h0,        1, 2'b01, 1, 16'h0000);
        vecs[16] = mk(1, 0, 2'b10, 0, 16'h0014, 32'h0,        32'h12345678, 32'h0,        1, 2'b10, 5, 16'h001E);
        vecs[17] = mk(1, 1, 2'b10, 0, 16'h0018, 32'h55555555, 32'h0,        32'h0,        1, 2'b10, 5, 16'h001E);
        vecs[18] = mk(0, 0, 2'b10, 0, 16'h0010, 32'h0,        32'h800000F0, 32'h800000F0, 0, 2'b00, 3, 16'h0006);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_enable", {31'd0, enable}, 32'd0);
        chk("rst_readnotwrite", {31'd0, rnw}, 32'd1);
        chk("rst_data_oe", {31'd0, data_oe}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {29'd0, err, err_code}, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_address", {16'd0, address}, 32'd0);
        chk("rst_data_out", data_out, 32'd0);

        for (int i = 0; i < 18; i++) run_vec(i, vecs[i]);

        // reset asserted while the word store is in its write cycle
        @(posedge clk);
        #1;
        mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'b10; mem_signed = 1'b0;
        mem_addr = 16'h0018; mem_wdata = 32'h12345678;
        @(negedge clk);
        @(negedge clk);
        chk("wr_enable", {31'd0, enable}, 32'd1);
        chk("wr_readnotwrite", {31'd0, rnw}, 32'd0);
        chk("wr_data_oe", {31'd0, data_oe}, 32'd1);
        chk("wr_address", {16'd0, address}, 32'h0018);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_enable", {31'd0, enable}, 32'd0);
        chk("async_rst_data_oe", {31'd0, data_oe}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_req = 1'b0;
        saw_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("no_done_after_rst", {31'd0, saw_done}, 32'd0);
        last_load = '0;
        run_vec(18, vecs[18]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
